// File: rtl/wb_pkg.sv
// Shared constants for the write-back port arbiter: data/address widths,
// requester index assignments and a small index-width helper.
package wb_pkg;

  localparam int XLEN         = 32;
  localparam int AW           = 5;
  localparam int NREQ_DEFAULT = 3;

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_MDU = 2;

  // Width of an index into n requesters; never below 1 bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from ptr upward (wrapping) for the first set
// request and moves ptr just past the winner when advance is high.
module rr_arbiter
  import wb_pkg::*;
#(
  parameter  int NREQ = NREQ_DEFAULT,
  localparam int IW   = idx_w(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

  logic [IW-1:0]   ptr_reg;
  logic [IW-1:0]   ptr_next;
  logic [NREQ-1:0] gnt_next;
  logic [IW-1:0]   idx_next;
  logic            found;
  int              pos;

  always_comb begin
    gnt_next = '0;
    idx_next = '0;
    found    = 1'b0;
    pos      = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(ptr_reg) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      if (!found && req[pos]) begin
        found         = 1'b1;
        gnt_next[pos] = 1'b1;
        idx_next      = IW'(pos);
      end
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (advance && found) begin
      ptr_next = (idx_next == IW'(NREQ - 1)) ? '0 : idx_next + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_reg <= '0;
    else     ptr_reg <= ptr_next;
  end

  assign gnt     = gnt_next;
  assign gnt_idx = idx_next;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port among the write-back sources: x0 writes
// are absorbed, one non-x0 write per cycle is granted round-robin and registered.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int XLEN = wb_pkg::XLEN,
  parameter int AW   = wb_pkg::AW,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_rd,
  output logic [XLEN-1:0]      rf_wd,
  output logic [CNTW-1:0]      contention_cnt
);

  localparam int IW = idx_w(NREQ);

  logic [NREQ-1:0] is_x0;
  logic [NREQ-1:0] nz_req;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_any;
  logic            denied;

  logic            rf_we_reg;
  logic [AW-1:0]   rf_rd_reg;
  logic [XLEN-1:0] rf_wd_reg;
  logic [CNTW-1:0] cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign is_x0[gi]     = req_valid[gi] && (req_rd[gi*AW +: AW] == '0);
      assign nz_req[gi]    = req_valid[gi] && (req_rd[gi*AW +: AW] != '0);
      // x0 writes bypass arbitration; nothing is accepted while in reset.
      assign req_ready[gi] = !rst && (is_x0[gi] || gnt[gi]);
    end
  endgenerate

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (nz_req),
    .advance (!rst),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign gnt_any = |gnt;
  assign denied  = |(nz_req & ~gnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_reg <= 1'b0;
      rf_rd_reg <= '0;
      rf_wd_reg <= '0;
    end else if (gnt_any) begin
      rf_we_reg <= 1'b1;
      rf_rd_reg <= req_rd[int'(gnt_idx)*AW +: AW];
      rf_wd_reg <= req_data[int'(gnt_idx)*XLEN +: XLEN];
    end else begin
      rf_we_reg <= 1'b0;
    end
  end

  // Saturating: a long stall must not wrap back to a small count.
  always_ff @(posedge clk) begin
    if (rst)                          cnt_reg <= '0;
    else if (denied && cnt_reg != '1) cnt_reg <= cnt_reg + CNTW'(1);
  end

  assign rf_we          = rf_we_reg;
  assign rf_rd          = rf_rd_reg;
  assign rf_wd          = rf_wd_reg;
  assign contention_cnt = cnt_reg;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed-vector bench: stimulus pushes the expected per-cycle outputs into a
// queue and a negedge monitor pops and compares them.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [14:0] req_rd;
  logic [95:0] req_data;

  logic [2:0]  req_ready, req_ready2;
  logic        rf_we, rf_we2;
  logic [4:0]  rf_rd, rf_rd2;
  logic [31:0] rf_wd, rf_wd2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;

  always #5 clk = ~clk;

  wb_port_arbiter #(.NREQ(3), .XLEN(32), .AW(5), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
    .req_ready(req_ready), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd),
    .contention_cnt(cnt)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  wb_port_arbiter #(.NREQ(3), .XLEN(32), .AW(5), .CNTW(2)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
    .req_ready(req_ready2), .rf_we(rf_we2), .rf_rd(rf_rd2), .rf_wd(rf_wd2),
    .contention_cnt(cnt2)
  );

  typedef struct {
    string       nm;
    logic [2:0]  rdy;
    logic        we;
    logic        chk_rd;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [15:0] cnt;
    logic        chk2;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  localparam logic [31:0] DA = 32'hA0A0_A0A0;
  localparam logic [31:0] DB = 32'hB1B1_B1B1;
  localparam logic [31:0] DC = 32'hC2C2_C2C2;

  task automatic check(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s.%s actual=%h required=%h", nm, fld, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      check(mon_e.nm, "req_ready", 32'(req_ready), 32'(mon_e.rdy));
      check(mon_e.nm, "rf_we", 32'(rf_we), 32'(mon_e.we));
      if (mon_e.chk_rd) begin
        check(mon_e.nm, "rf_rd", 32'(rf_rd), 32'(mon_e.rd));
        check(mon_e.nm, "rf_wd", rf_wd, mon_e.wd);
      end
      check(mon_e.nm, "contention_cnt", 32'(cnt), 32'(mon_e.cnt));
      if (mon_e.chk2) check(mon_e.nm, "sat_cnt", 32'(cnt2), 32'(mon_e.cnt2));
      $display("[TB] %s ready=%b we=%b rd=%0d wd=%h cnt=%0d cnt2=%0d",
               mon_e.nm, req_ready, rf_we, rf_rd, rf_wd, cnt, cnt2);
    end
  end

  task automatic step(input string nm, input logic r, input logic [2:0] v,
                      input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                      input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                      input logic [2:0] er, input logic ew, input logic chkrd,
                      input logic [4:0] erd, input logic [31:0] ewd, input logic [15:0] ec,
                      input logic chk2, input logic [1:0] ec2);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = r;
    req_valid = v;
    req_rd    = {a2, a1, a0};
    req_data  = {d2, d1, d0};
    e.nm = nm; e.rdy = er; e.we = ew; e.chk_rd = chkrd; e.rd = erd; e.wd = ewd;
    e.cnt = ec; e.chk2 = chk2; e.cnt2 = ec2;
    q.push_back(e);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 3'b111;
    req_rd    = {5'd3, 5'd2, 5'd0};
    req_data  = '0;

    // Reset with every requester valid, including an x0 write.
    step("rst0", 1, 3'b111, 0, 2, 3, 0, 0, 0, 3'b000, 0, 1, 0, 0, 0, 1, 0);
    step("rst1", 1, 3'b111, 0, 2, 3, 0, 0, 0, 3'b000, 0, 1, 0, 0, 0, 1, 0);

    // Single requester, then output pulse and hold.
    step("single",    0, 3'b010, 0, 7, 0, 0, 32'hDEADBEEF, 0, 3'b010, 0, 1, 0, 0, 0, 0, 0);
    step("single_wr", 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 1, 1, 7, 32'hDEADBEEF, 0, 0, 0);
    step("pre_fair",  0, 3'b100, 0, 0, 9, 0, 0, 32'h2222_2222,
         3'b100, 0, 1, 7, 32'hDEADBEEF, 0, 0, 0);

    // Fairness: all valid for six cycles starting from ptr=0.
    step("fair1", 0, 3'b111, 1, 2, 3, DA, DB, DC, 3'b001, 1, 1, 9, 32'h2222_2222, 0, 0, 0);
    step("fair2", 0, 3'b111, 1, 2, 3, DA, DB, DC, 3'b010, 1, 1, 1, DA, 1, 0, 0);
    step("fair3", 0, 3'b111, 1, 2, 3, DA, DB, DC, 3'b100, 1, 1, 2, DB, 2, 0, 0);
    step("fair4", 0, 3'b111, 1, 2, 3, DA, DB, DC, 3'b001, 1, 1, 3, DC, 3, 0, 0);
    step("fair5", 0, 3'b111, 1, 2, 3, DA, DB, DC, 3'b010, 1, 1, 1, DA, 4, 0, 0);
    step("fair6", 0, 3'b111, 1, 2, 3, DA, DB, DC, 3'b100, 1, 1, 2, DB, 5, 0, 0);

    // x0 absorb, then confirm ptr=2 by the next grant.
    step("x0_absorb", 0, 3'b111, 0, 5, 0, 0, 32'h55, 0, 3'b111, 1, 1, 3, DC, 6, 0, 0);
    step("x0_ptr",    0, 3'b111, 1, 2, 3, DA, DB, DC, 3'b100, 1, 1, 5, 32'h55, 6, 0, 0);

    // Reset arriving while a granted write sits in the output register.
    step("rstmid_gnt", 0, 3'b001, 3, 0, 0, 32'h33, 0, 0, 3'b001, 1, 1, 3, DC, 7, 0, 0);
    step("rstmid_rst", 1, 3'b011, 3, 4, 0, 32'h33, 32'h44, 0, 3'b000, 1, 1, 3, 32'h33, 7, 0, 0);
    step("post_rst1",  0, 3'b011, 6, 4, 0, 32'h66, 32'h44, 0, 3'b001, 0, 1, 0, 0, 0, 0, 0);
    step("post_rst2",  0, 3'b010, 6, 4, 0, 32'h66, 32'h44, 0, 3'b010, 1, 1, 6, 32'h66, 1, 0, 0);
    step("post_rst3",  0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 1, 1, 4, 32'h44, 1, 0, 0);

    // Saturation of the 2-bit counter under continuous contention.
    step("sat_rst", 1, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 0, 0);
    step("sat1", 0, 3'b111, 1, 2, 3, DA, DB, DC, 3'b001, 0, 1, 0, 0, 0, 1, 0);
    step("sat2", 0, 3'b111, 1, 2, 3, DA, DB, DC, 3'b010, 1, 1, 1, DA, 1, 1, 1);
    step("sat3", 0, 3'b111, 1, 2, 3, DA, DB, DC, 3'b100, 1, 1, 2, DB, 2, 1, 2);
    step("sat4", 0, 3'b111, 1, 2, 3, DA, DB, DC, 3'b001, 1, 1, 3, DC, 3, 1, 3);
    step("sat5", 0, 3'b111, 1, 2, 3, DA, DB, DC, 3'b010, 1, 1, 1, DA, 4, 1, 3);
    step("sat6", 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 1, 1, 2, DB, 5, 1, 3);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      fails++;
      $display("[TB] FAIL drain pending=%0d required=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the register file's single write port among several write-back sources: ALU, load/store unit and multiply/divide unit. Each source presents a write request on a valid/ready handshake. The block grants at most one non-x0 request per cycle using round-robin priority and registers the winner onto the register file write port. Writes to x0 are absorbed without using the port. A saturating contention counter is provided for performance monitoring.

## Interface
Parameters:
- NREQ, 3, number of write-back requesters (≥2)
- XLEN, 32, data width
- AW, 5, register address width
- CNTW, 16, contention counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  per-requester write request valid
- req_rd  in  NREQ*AW  destination register per requester; requester i occupies bits [i*AW +: AW]
- req_data  in  NREQ*XLEN  write data per requester; requester i occupies bits [i*XLEN +: XLEN]
- req_ready  out  NREQ  request accepted this cycle
- rf_we  out  1  register file write enable (registered)
- rf_rd  out  AW  register file write address (registered)
- rf_wd  out  XLEN  register file write data (registered)
- contention_cnt  out  CNTW  saturating count of cycles in which a valid non-x0 request was denied

## Operation
- A transfer occurs on requester i when req_valid[i] && req_ready[i] at a rising edge.
- Requesters hold valid, rd and data stable until the transfer completes.
- req_valid must not depend on req_ready.
- req_ready is combinational from req_valid, req_rd and the pointer. The port has no downstream backpressure.
- **x0 requests** (req_rd == 0):
  - req_ready[i] = req_valid[i], unconditionally.
  - Several x0 requests in one cycle are all accepted.
  - They never win the grant, never move the pointer and never assert rf_we.
- **Non-x0 requests:**
  - Search starts at index ptr and proceeds ptr, ptr+1, …, NREQ-1, 0, …, ptr-1.
  - The first valid non-x0 requester is granted; req_ready is 1 for it and 0 for all other non-x0 requesters.
  - On a grant to i: ptr ← (i+1) mod NREQ. With no grant, ptr holds.
- **Output register:**
  - On a grant: rf_we ← 1, rf_rd ← winner's rd, rf_wd ← winner's data.
  - With no grant: rf_we ← 0; rf_rd and rf_wd hold.
- **Contention counter:**
  - Increments by 1 in any cycle where at least one valid non-x0 requester is not granted.
  - Saturates at 2^CNTW−1; never wraps.
- **Same-rd ordering:** two requesters targeting the same rd in one cycle are serialized in round-robin order. The block enforces no program order; issue logic prevents WAW between sources.
- **Reset** (rst high at an edge):
  - ptr ← 0, rf_we ← 0, rf_rd ← 0, rf_wd ← 0, contention_cnt ← 0.
  - req_ready is forced to 0 while rst is high, including for x0 requests.
  - A write held in the output register when rst asserts is dropped and never reaches the register file.

## Timing
- Request accepted at edge N.
- rf_we/rf_rd/rf_wd are valid during cycle N+1.
- Register file updated at edge N+2.
- Forwarding logic elsewhere uses rf_we/rf_rd/rf_wd as the in-flight write source during cycle N+1.
- Throughput: one non-x0 write per cycle sustained; any number of x0 acceptances per cycle.
- Worst-case wait for a continuously valid non-x0 requester: NREQ−1 cycles.
- Reset values of all outputs: req_ready=0, rf_we=0, rf_rd=0, rf_wd=0, contention_cnt=0.

## Structure
- Shared package wb_pkg holds:
  - XLEN and AW
  - requester index constants REQ_ALU=0, REQ_LSU=1, REQ_MDU=2
  - NREQ_DEFAULT=3
- Sub-module rr_arbiter (parameter NREQ):
  - Inputs: request vector, clk, rst, advance enable.
  - Outputs: one-hot grant and the granted index.
  - Owns the ptr register.
- wb_port_arbiter owns x0 filtering, the output register and the contention counter.

## Test plan
- **Reset:** hold rst 2 cycles with all req_valid=1.
  - Expected: req_ready=000, rf_we=0, contention_cnt=0 throughout.
- **Single requester:** after reset, only requester 1 valid with rd=7, data=0xDEADBEEF.
  - Expected: req_ready=010 that cycle; next cycle rf_we=1, rf_rd=7, rf_wd=0xDEADBEEF; the following cycle rf_we=0.
- **Fairness:** all three valid, non-x0, held continuously for 6 cycles, starting from ptr=0.
  - Expected: grant order 0,1,2,0,1,2; contention_cnt=6.
- **x0 absorb:** requesters 0 and 2 valid with rd=0, requester 1 valid with rd=5.
  - Expected: req_ready=111 in one cycle; next cycle rf_we=1 with rf_rd=5; ptr=2.
- **Reset mid-operation:** grant requester 0 (rd=3) at edge N, assert rst at edge N+1.
  - Expected: rf_we=0 after edge N+1; register x3 unchanged; next grant after reset goes to requester 0.
- **Saturation:** CNTW=2, continuous contention for 5 cycles.
  - Expected: contention_cnt reads 1,2,3,3,3.
